// File: rtl/g711_codec_pipe.sv
// g711_codec_pipe: two-stage streaming G.711 compressor (u-law / A-law per sample).
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_data/in_alaw   : signed linear sample and mode select (0 = u-law, 1 = A-law)
//   in_valid/in_ready : input handshake; in_ready is combinational
//   out_code          : {sign, seg[2:0], mant[3:0]}
//   out_valid/out_ready : output handshake; out_code held while stalled
//   sat_clr/sat_cnt   : saturation event counter and its synchronous clear
// Optional macro CODEC_STATS_EN: builds the saturation counter. When it is
// undefined, sat_cnt is tied to zero and sat_clr is ignored.
module g711_codec_pipe #(
  parameter int unsigned IN_W  = 14,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [IN_W-1:0] in_data,
  input  logic                   in_alaw,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             out_code,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   sat_clr,
  output logic [CNT_W-1:0]       sat_cnt
);

  // Pipeline state
  logic        s1_valid_q, s1_valid_d;
  logic        s1_alaw_q,  s1_alaw_d;
  logic        s1_sign_q,  s1_sign_d;
  logic [12:0] s1_mag_q,   s1_mag_d;
  logic [7:0]  out_code_q, out_code_d;
  logic        out_valid_q, out_valid_d;

  // Handshake
  logic s2_load;
  logic accept;

  // Stage-1 conditioning
  logic [IN_W-14:0] top_bits;
  logic             over_range;
  logic [13:0]      x;
  logic             sign;
  logic [13:0]      ulaw_mag;
  logic             mu_over;
  logic [12:0]      ulaw_biased;
  logic [11:0]      alaw_mag;
  logic             saturated;

  // Stage-2 encode
  logic [3:0]  pos;
  logic [12:0] shifted;
  logic [2:0]  enc_seg;
  logic [3:0]  enc_mant;

  assign s2_load  = ~out_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_load;
  assign accept   = in_valid & in_ready;

  // Out of 14-bit range when the bits above bit 12 are not all copies of the sign.
  assign top_bits = in_data[IN_W-1:13];

  always_comb begin
    over_range  = ~((&top_bits) | ~(|top_bits));
    x           = in_data[13:0];
    if (over_range) begin
      x = in_data[IN_W-1] ? 14'h2000 : 14'h1FFF;
    end
    sign        = x[13];
    ulaw_mag    = sign ? (~x + 14'd1) : x;
    mu_over     = ulaw_mag > 14'd8158;
    ulaw_biased = (mu_over ? 13'd8158 : ulaw_mag[12:0]) + 13'd33;
    // x >>> 1 keeps bits [12:1]; one's complement folds negatives onto 0..4095.
    alaw_mag    = sign ? ~x[12:1] : x[12:1];
    saturated   = over_range | (~in_alaw & mu_over);
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_alaw_d  = s1_alaw_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (accept) begin
      s1_alaw_d = in_alaw;
      s1_sign_d = sign;
      s1_mag_d  = in_alaw ? {1'b0, alaw_mag} : ulaw_biased;
    end
  end

  always_comb begin
    pos      = 4'd5;
    shifted  = '0;
    enc_seg  = '0;
    enc_mant = '0;
    if (!s1_alaw_q) begin
      for (int unsigned i = 6; i <= 12; i++) begin
        if (s1_mag_q[i]) begin
          pos = 4'(i);
        end
      end
      shifted  = s1_mag_q >> (pos - 4'd4);
      enc_seg  = 3'(pos - 4'd5);
      enc_mant = shifted[3:0];
    end else if (s1_mag_q[11:5] == 7'd0) begin
      enc_seg  = '0;
      enc_mant = s1_mag_q[4:1];
    end else begin
      for (int unsigned i = 6; i <= 11; i++) begin
        if (s1_mag_q[i]) begin
          pos = 4'(i);
        end
      end
      shifted  = s1_mag_q >> (pos - 4'd4);
      enc_seg  = 3'(pos - 4'd4);
      enc_mant = shifted[3:0];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_code_d = {s1_sign_q, enc_seg, enc_mant};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_alaw_q   <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mag_q    <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_alaw_q   <= s1_alaw_d;
      s1_sign_q   <= s1_sign_d;
      s1_mag_q    <= s1_mag_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
    end
  end

  assign out_code  = out_code_q;
  assign out_valid = out_valid_q;

`ifdef CODEC_STATS_EN
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (accept && saturated && !(&sat_cnt_q)) begin
      sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = sat_clr ^ saturated;
  assign sat_cnt      = '0;
`endif

endmodule

// File: tb/tb_g711_codec_pipe.sv
module tb_g711_codec_pipe;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned CNT_W = 4;
  localparam int          CNT_MAX = 15;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic signed [IN_W-1:0] in_data;
  logic                   in_alaw;
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             out_code;
  logic                   out_valid;
  logic                   out_ready;
  logic                   sat_clr;
  logic [CNT_W-1:0]       sat_cnt;

  int errors = 0;
  int checks = 0;
  int exp_sat = 0;

  g711_codec_pipe #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_alaw   (in_alaw),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_clr   (sat_clr),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         data;
    logic       alaw;
    logic [7:0] code;
    logic       sat;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_cnt();
`ifdef CODEC_STATS_EN
    return exp_sat;
`else
    return 0;
`endif
  endfunction

  function automatic void note_sat(input bit s);
    if (s && exp_sat < CNT_MAX) exp_sat++;
  endfunction

  function automatic int clamp14(input int v);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  function automatic bit model_sat(input int v, input bit alaw);
    int x;
    x = clamp14(v);
    if (x != v) return 1'b1;
    if (!alaw && ((x < 0 ? -x : x) > 8158)) return 1'b1;
    return 1'b0;
  endfunction

  // Segment found by repeated threshold comparison rather than bit scanning.
  function automatic logic [7:0] model_code(input int v, input bit alaw);
    int x, m, b, seg, mant;
    bit s;
    x = clamp14(v);
    s = (x < 0);
    if (!alaw) begin
      m = s ? -x : x;
      if (m > 8158) m = 8158;
      b = m + 33;
      seg = 0;
      while (b >= (64 << seg)) seg++;
      mant = (b >> (seg + 1)) & 15;
    end else begin
      m = s ? ((-x - 1) >> 1) : (x >> 1);
      if (m < 32) begin
        seg = 0;
        mant = (m >> 1) & 15;
      end else begin
        seg = 1;
        while (m >= (32 << seg)) seg++;
        mant = (m >> seg) & 15;
      end
    end
    return {s, 3'(seg), 4'(mant)};
  endfunction

  task automatic send_one(input int v, input logic alaw, input logic [7:0] code, input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'(v);
    in_alaw   = alaw;
    #1;
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({nm, " not yet valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk({nm, " valid"}, 32'(out_valid), 32'd1);
    chk({nm, " code"}, 32'(out_code), 32'(code));
  endtask

  task automatic run_stream(input int n, input int base, input int step,
                            input bit use_bp, input bit alt_mode, input string nm);
    logic [15:0] bp_pat;
    logic [7:0]  exp_q[$];
    logic [7:0]  held;
    logic [7:0]  e;
    int  sent, rcvd, occ, cyc, v;
    bit  stalled_prev, acc, xfer, md;
    bp_pat = 16'b0110_0010_1100_1001;
    sent = 0; rcvd = 0; occ = 0; cyc = 0;
    stalled_prev = 1'b0;
    held = '0;
    while ((sent < n || rcvd < n) && cyc < 300) begin
      @(negedge clk);
      out_ready = use_bp ? bp_pat[cyc % 16] : 1'b1;
      v  = base + sent * step;
      md = alt_mode ? sent[0] : 1'b0;
      if (sent < n) begin
        in_valid = 1'b1;
        in_data  = 16'(v);
        in_alaw  = md;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk({nm, " in_ready"}, 32'(in_ready), 32'(!(occ == 2 && !out_ready)));
      if (stalled_prev) begin
        chk({nm, " stall valid"}, 32'(out_valid), 32'd1);
        chk({nm, " stall code"}, 32'(out_code), 32'(held));
      end
      xfer = out_valid && out_ready;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          chk({nm, " extra output"}, 32'(out_code), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk({nm, " code"}, 32'(out_code), 32'(e));
        end
        rcvd++;
      end
      stalled_prev = out_valid && !out_ready;
      held = out_code;
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(model_code(v, md));
        note_sat(model_sat(v, md));
        sent++;
      end
      occ = occ + int'(acc) - int'(xfer);
      cyc++;
    end
    chk({nm, " received count"}, 32'(rcvd), 32'(n));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0,      1'b0, 8'h00, 1'b0};
    vecs[1]  = '{100,    1'b0, 8'h20, 1'b0};
    vecs[2]  = '{-100,   1'b0, 8'hA0, 1'b0};
    vecs[3]  = '{-20000, 1'b0, 8'hFF, 1'b1};
    vecs[4]  = '{8191,   1'b0, 8'h7F, 1'b1};
    vecs[5]  = '{8158,   1'b0, 8'h7F, 1'b0};
    vecs[6]  = '{8159,   1'b0, 8'h7F, 1'b1};
    vecs[7]  = '{-8192,  1'b0, 8'hFF, 1'b1};
    vecs[8]  = '{1,      1'b0, 8'h01, 1'b0};
    vecs[9]  = '{30,     1'b0, 8'h0F, 1'b0};
    vecs[10] = '{31,     1'b0, 8'h10, 1'b0};
    vecs[11] = '{100,    1'b1, 8'h19, 1'b0};
    vecs[12] = '{-2,     1'b1, 8'h80, 1'b0};
    vecs[13] = '{8191,   1'b1, 8'h7F, 1'b0};
    vecs[14] = '{40,     1'b1, 8'h0A, 1'b0};
    vecs[15] = '{20000,  1'b1, 8'h7F, 1'b1};
    vecs[16] = '{-20000, 1'b1, 8'hFF, 1'b1};
    vecs[17] = '{64,     1'b1, 8'h10, 1'b0};
    vecs[18] = '{63,     1'b1, 8'h0F, 1'b0};
    vecs[19] = '{-8192,  1'b1, 8'hFF, 1'b0};

    rst_n     = 1'b0;
    in_data   = '0;
    in_alaw   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_code", 32'(out_code), 32'h00);
    chk("reset sat_cnt", 32'(sat_cnt), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      send_one(vecs[i].data, vecs[i].alaw, vecs[i].code, $sformatf("vec%0d", i));
      note_sat(vecs[i].sat);
    end
    #1;
    chk("sat_cnt after table", 32'(sat_cnt), 32'(exp_cnt()));

    // Clear wins over a coincident saturating sample.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'(-20000);
    in_alaw  = 1'b0;
    sat_clr  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    sat_clr  = 1'b0;
    exp_sat  = 0;
    #1;
    chk("sat_clr priority", 32'(sat_cnt), 32'd0);
    @(negedge clk);
    #1;
    chk("sat_clr sample code", 32'(out_code), 32'hFF);

    // Mixed modes back-to-back at full rate.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (c < 6) begin
        in_valid = 1'b1;
        in_data  = 16'sd100;
        in_alaw  = c[0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 2) begin
        chk($sformatf("mixed valid %0d", c), 32'(out_valid), 32'd1);
        chk($sformatf("mixed code %0d", c), 32'(out_code), (c % 2 == 1) ? 32'h19 : 32'h20);
      end
    end
    @(negedge clk);

    run_stream(10, -9000, 2000, 1'b1, 1'b1, "bp ramp");
    #1;
    chk("sat_cnt after ramp", 32'(sat_cnt), 32'(exp_cnt()));

    run_stream(17, 20000, 0, 1'b0, 1'b0, "sat burst");
    #1;
    chk("sat_cnt ceiling", 32'(sat_cnt), 32'(exp_cnt()));

    // Reset with two samples in flight.
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'sd20000; in_alaw = 1'b0;
    @(negedge clk);
    in_data = 16'(-20000);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("pre-reset valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(out_valid), 32'd0);
    chk("async reset out_code", 32'(out_code), 32'h00);
    chk("async reset sat_cnt", 32'(sat_cnt), 32'd0);
    chk("async reset in_ready", 32'(in_ready), 32'd1);
    exp_sat = 0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("flushed after reset", 32'(out_valid), 32'd0);
    send_one(100, 1'b0, 8'h20, "post reset");
    chk("post reset sat_cnt", 32'(sat_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
